// File: rtl/cache_dre_pkg.sv
// Shared definitions for the cache_dre_tracker block.
// Contents:
//   clr_state_e      - flash-clear FSM state encoding (IDLE / CLEAR)
//   sel_width()      - select-field width for n choices, minimum 1 bit
//   way_sel_width()  - width of a way select for a given way count
//   word_sel_width() - width of a word-within-line select
package cache_dre_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    function automatic int sel_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

    function automatic int way_sel_width(input int ways);
        return sel_width(ways);
    endfunction

    function automatic int word_sel_width(input int line_bytes, input int word_bytes);
        return sel_width(line_bytes / word_bytes);
    endfunction

endpackage

// File: rtl/cache_dre_ram.sv
// Readable-enable storage: one LINE_BYTES-bit vector per (set, way).
// Simple dual-port: one registered read port, one write port with a
// per-way write enable so that a single write can touch one way (normal
// update) or every way of a set at once (flash clear).
// Ports:
//   clk, rst_n      clock, async active-low reset (read register only)
//   rd_en           capture mem[rd_way][rd_addr] into rd_data
//   rd_addr, rd_way read location
//   rd_data         registered read vector
//   wr_addr         set index to write
//   wr_way_en       one enable bit per way
//   wr_data         vector written to every enabled way
module cache_dre_ram
    import cache_dre_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int WAYS       = 4,
    parameter int LINE_BYTES = 8
)(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            rd_en,
    input  logic [ADDR_WIDTH-1:0]           rd_addr,
    input  logic [way_sel_width(WAYS)-1:0]  rd_way,
    output logic [LINE_BYTES-1:0]           rd_data,
    input  logic [ADDR_WIDTH-1:0]           wr_addr,
    input  logic [WAYS-1:0]                 wr_way_en,
    input  logic [LINE_BYTES-1:0]           wr_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [LINE_BYTES-1:0] mem_r [WAYS][DEPTH];

    // Storage array write, one enable per way.
    always_ff @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            if (wr_way_en[w]) begin
                mem_r[w][wr_addr] <= wr_data;
            end
        end
    end

    // Registered read port; old data is returned on a same-address write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem_r[rd_way][rd_addr];
        end
    end

endmodule

// File: rtl/cache_dre_tracker.sv
// Cache readable-enable (DRE) tracker.
// Holds a per-byte readable-enable vector for every (set, way) of a cache,
// answers "are all requested bytes of this word readable" one cycle after a
// read request, and flash-clears the whole array on request and after reset.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   clr_req / clr_busy / clr_done  start clear, clear running, end-of-clear pulse
//   rd_en, rd_addr, rd_way, rd_word, rd_be  read request
//   rd_valid, rd_re_all, rd_readable        read result (one cycle later)
//   wr_en, wr_addr, wr_way, wr_re           overwrite one entry
// Optional feature macro: CACHE_DRE_BYPASS_EN
//   defined   - a read colliding with a same-cycle write returns the new vector
//   undefined - the collision returns the stored (pre-write) vector
module cache_dre_tracker
    import cache_dre_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int WAYS       = 4,
    parameter int LINE_BYTES = 8,
    parameter int WORD_BYTES = 4
)(
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic                                               clr_req,
    output logic                                               clr_busy,
    output logic                                               clr_done,
    input  logic                                               rd_en,
    input  logic [ADDR_WIDTH-1:0]                              rd_addr,
    input  logic [way_sel_width(WAYS)-1:0]                     rd_way,
    input  logic [word_sel_width(LINE_BYTES, WORD_BYTES)-1:0]  rd_word,
    input  logic [WORD_BYTES-1:0]                              rd_be,
    output logic                                               rd_valid,
    output logic [LINE_BYTES-1:0]                              rd_re_all,
    output logic                                               rd_readable,
    input  logic                                               wr_en,
    input  logic [ADDR_WIDTH-1:0]                              wr_addr,
    input  logic [way_sel_width(WAYS)-1:0]                     wr_way,
    input  logic [LINE_BYTES-1:0]                              wr_re
);

    localparam int WORD_W = word_sel_width(LINE_BYTES, WORD_BYTES);
    localparam int WORDS  = LINE_BYTES / WORD_BYTES;

    clr_state_e             state_r;
    clr_state_e             state_nxt_s;
    logic [ADDR_WIDTH-1:0]  cnt_r;
    logic                   clr_done_r;
    logic                   last_set_s;
    logic                   wr_accept_s;

    logic [ADDR_WIDTH-1:0]  ram_wr_addr_s;
    logic [WAYS-1:0]        ram_wr_en_s;
    logic [LINE_BYTES-1:0]  ram_wr_data_s;
    logic [LINE_BYTES-1:0]  ram_rd_data_s;

    logic                   rd_valid_r;
    logic                   rd_clr_r;
    logic [WORD_BYTES-1:0]  rd_be_r;
    logic [WORD_W-1:0]      rd_word_r;
    logic [LINE_BYTES-1:0]  rd_vec_s;
    logic [WORD_BYTES-1:0]  word_re_s;

`ifdef CACHE_DRE_BYPASS_EN
    logic                   byp_hit_r;
    logic [LINE_BYTES-1:0]  byp_data_r;
`endif

    assign last_set_s  = (cnt_r == {ADDR_WIDTH{1'b1}});
    // A clear request in the same cycle takes priority and drops the write.
    assign wr_accept_s = (state_r == ST_IDLE) && wr_en && !clr_req;

    // FSM state register; reset lands in CLEAR so the array self-initialises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_CLEAR;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (clr_req) begin
                    state_nxt_s = ST_CLEAR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (last_set_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            default: begin
                state_nxt_s = ST_CLEAR;
            end
        endcase
    end

    // FSM outputs.
    always_comb begin
        clr_busy = (state_r == ST_CLEAR);
        clr_done = clr_done_r;
    end

    // Clear set counter (wraps naturally) and end-of-clear pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r      <= {ADDR_WIDTH{1'b0}};
            clr_done_r <= 1'b0;
        end else begin
            clr_done_r <= (state_r == ST_CLEAR) && last_set_s;
            if (state_r == ST_CLEAR) begin
                cnt_r <= cnt_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end else if (clr_req) begin
                cnt_r <= {ADDR_WIDTH{1'b0}};
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Write-port steering: clear zeroes a whole set, otherwise one way.
    always_comb begin
        ram_wr_addr_s = wr_addr;
        ram_wr_en_s   = {WAYS{1'b0}};
        ram_wr_data_s = wr_re;
        if (state_r == ST_CLEAR) begin
            ram_wr_addr_s = cnt_r;
            ram_wr_en_s   = {WAYS{1'b1}};
            ram_wr_data_s = {LINE_BYTES{1'b0}};
        end else if (wr_accept_s) begin
            ram_wr_en_s[wr_way] = 1'b1;
        end else begin
            ram_wr_en_s = {WAYS{1'b0}};
        end
    end

    cache_dre_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WAYS       (WAYS),
        .LINE_BYTES (LINE_BYTES)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_way    (rd_way),
        .rd_data   (ram_rd_data_s),
        .wr_addr   (ram_wr_addr_s),
        .wr_way_en (ram_wr_en_s),
        .wr_data   (ram_wr_data_s)
    );

    // Read request pipeline: remembers what the answer must be qualified by.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_r <= 1'b0;
            rd_clr_r   <= 1'b0;
            rd_be_r    <= {WORD_BYTES{1'b0}};
            rd_word_r  <= {WORD_W{1'b0}};
        end else begin
            rd_valid_r <= rd_en;
            if (rd_en) begin
                rd_clr_r  <= (state_r == ST_CLEAR);
                rd_be_r   <= rd_be;
                rd_word_r <= rd_word;
            end
        end
    end

`ifdef CACHE_DRE_BYPASS_EN
    // Forward a same-cycle accepted write to a colliding read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byp_hit_r  <= 1'b0;
            byp_data_r <= {LINE_BYTES{1'b0}};
        end else if (rd_en) begin
            byp_hit_r  <= wr_accept_s && (wr_addr == rd_addr) && (wr_way == rd_way);
            byp_data_r <= wr_re;
        end
    end
`endif

    // Result vector: reads issued during a clear see an all-zero line.
    always_comb begin
        rd_vec_s = ram_rd_data_s;
        if (rd_clr_r) begin
            rd_vec_s = {LINE_BYTES{1'b0}};
`ifdef CACHE_DRE_BYPASS_EN
        end else if (byp_hit_r) begin
            rd_vec_s = byp_data_r;
`endif
        end else begin
            rd_vec_s = ram_rd_data_s;
        end
    end

    // Select the requested word out of the line.
    always_comb begin
        word_re_s = {WORD_BYTES{1'b0}};
        for (int k = 0; k < WORDS; k++) begin
            if (rd_word_r == WORD_W'(k)) begin
                word_re_s = rd_vec_s[k*WORD_BYTES +: WORD_BYTES];
            end
        end
    end

    // Read result outputs.
    always_comb begin
        rd_valid    = rd_valid_r;
        rd_re_all   = rd_vec_s;
        rd_readable = rd_valid_r & (&(~rd_be_r | word_re_s));
    end

endmodule
